// File: rtl/pc_redirect_if.sv
// pc_redirect_if: fetch/decode control-flow signals between the PC mux, decode and the redirect controller.
interface pc_redirect_if #(
  parameter int PC_W = 7,
  parameter int DATA_W = 16,
  parameter int REG_W = 3
);
  logic [PC_W-1:0] PC_next, ImmD, JTargetD;
  logic BranchD, BranchNeD, JumpD, JRD;
  logic [DATA_W-1:0] RD1D, RD2D;
  logic [REG_W-1:0] RsD, RtD, WriteRegE, WriteRegM;
  logic RegWriteE, MemtoRegM;
  logic [PC_W-1:0] PCF, PC_plus1F, PC_BranchD, JR, ins_extend;
  logic [1:0] PCSrcD;
  logic StallF, StallD, FlushD, FlushE, ValidD, hazard_err;
  logic [7:0] taken_cnt;
  modport slave (
    input PC_next, BranchD, BranchNeD, JumpD, JRD, RD1D, RD2D, RsD, RtD, ImmD, JTargetD,
          RegWriteE, WriteRegE, MemtoRegM, WriteRegM,
    output PCF, PC_plus1F, PC_BranchD, JR, ins_extend, PCSrcD, StallF, StallD, FlushD, FlushE,
           ValidD, taken_cnt, hazard_err
  );
  modport master (
    output PC_next, BranchD, BranchNeD, JumpD, JRD, RD1D, RD2D, RsD, RtD, ImmD, JTargetD,
           RegWriteE, WriteRegE, MemtoRegM, WriteRegM,
    input PCF, PC_plus1F, PC_BranchD, JR, ins_extend, PCSrcD, StallF, StallD, FlushD, FlushE,
          ValidD, taken_cnt, hazard_err
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: PC/IF-ID registers, decode-stage branch/jump/JR resolution, hazard stall and flush control.
module pc_redirect_ctrl #(
  parameter int PC_W = 7,
  parameter int MAX_WAIT = 2
) (
  input logic clk,
  input logic rst,
  pc_redirect_if.slave bus
);
  typedef enum logic {RUN, WAIT} state_t;
  localparam int WC_W = $clog2(MAX_WAIT + 2);
  localparam logic [WC_W-1:0] WMAX = WC_W'(MAX_WAIT);
  state_t state, state_n;
  logic [WC_W-1:0] wait_cnt, wait_cnt_n;
  logic [PC_W-1:0] pc_plus1d;
  logic equal, br, use_rs, use_rt, hit_e, hit_m, hazard, err_set;
  logic [1:0] src;
  assign bus.PC_plus1F = bus.PCF + PC_W'(1);
  assign bus.PC_BranchD = pc_plus1d + bus.ImmD;
  assign bus.JR = bus.RD1D[PC_W-1:0];
  assign bus.ins_extend = bus.JTargetD;
  assign equal = bus.RD1D == bus.RD2D;
  assign br = (bus.BranchD & equal) | (bus.BranchNeD & ~equal);
  assign use_rt = bus.BranchD | bus.BranchNeD;
  assign use_rs = use_rt | bus.JRD;
  assign hit_e = bus.RegWriteE && bus.WriteRegE != '0 &&
                 ((use_rs && bus.WriteRegE == bus.RsD) || (use_rt && bus.WriteRegE == bus.RtD));
  assign hit_m = bus.MemtoRegM && bus.WriteRegM != '0 &&
                 ((use_rs && bus.WriteRegM == bus.RsD) || (use_rt && bus.WriteRegM == bus.RtD));
  assign hazard = bus.ValidD & (hit_e | hit_m);
  // A stall always wins over a redirect; an empty decode slot never redirects.
  always_comb begin
    src = (!bus.ValidD || hazard) ? 2'd0 : bus.JumpD ? 2'd3 : bus.JRD ? 2'd2 : br ? 2'd1 : 2'd0;
    bus.PCSrcD = src;
    bus.FlushD = src != 2'd0;
    bus.StallF = hazard;
    bus.StallD = hazard;
    bus.FlushE = hazard;
  end
  always_comb begin
    state_n = hazard ? WAIT : RUN;
    wait_cnt_n = !hazard ? '0 : state == RUN ? WC_W'(1) : (&wait_cnt) ? wait_cnt : wait_cnt + WC_W'(1);
    err_set = hazard && state == WAIT && wait_cnt >= WMAX;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      wait_cnt <= '0;
      bus.PCF <= '0;
      pc_plus1d <= '0;
      bus.ValidD <= 1'b0;
      bus.taken_cnt <= '0;
      bus.hazard_err <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_cnt_n;
      bus.hazard_err <= bus.hazard_err | err_set;
      if (!bus.StallF) bus.PCF <= bus.PC_next;
      if (!bus.StallD) begin
        bus.ValidD <= ~bus.FlushD;
        pc_plus1d <= bus.FlushD ? '0 : bus.PC_plus1F;
      end
      if (src != 2'd0 && bus.taken_cnt != 8'hFF) bus.taken_cnt <= bus.taken_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed stimulus with a per-cycle behavioural model and literal spot checks.
module tb_pc_redirect_ctrl;
  localparam int MAX_WAIT = 2;
  logic clk, rst;
  int checks = 0, failures = 0;
  pc_redirect_if bus();
  pc_redirect_ctrl #(.PC_W(7), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  // Environment PC mux fed by the controller's select and candidate targets.
  assign bus.PC_next = bus.PCSrcD == 2'd3 ? bus.ins_extend : bus.PCSrcD == 2'd2 ? bus.JR :
                       bus.PCSrcD == 2'd1 ? bus.PC_BranchD : bus.PC_plus1F;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  logic [6:0] m_pcf, m_p1d, n_pcf, n_p1d, tgt_b, m_pcf1;
  logic m_vd, m_err, n_vd, n_err, hz, eq, is_br, apply;
  logic [1:0] sel;
  int m_tc, n_tc, m_k, n_k;
  logic [50:0] act, exp;
  function automatic logic dep(input logic [2:0] r, input logic is_b, input logic is_j);
    return r != 0 && ((r == bus.RsD && (is_b || is_j)) || (r == bus.RtD && is_b));
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pcf = 0; m_p1d = 0; m_vd = 0; m_tc = 0; m_err = 0; m_k = 0;
      end
      eq = bus.RD1D == bus.RD2D;
      is_br = bus.BranchD || bus.BranchNeD;
      hz = m_vd && ((bus.RegWriteE && dep(bus.WriteRegE, is_br, bus.JRD)) ||
                    (bus.MemtoRegM && dep(bus.WriteRegM, is_br, bus.JRD)));
      tgt_b = m_p1d + bus.ImmD;
      m_pcf1 = m_pcf + 7'd1;
      sel = (!m_vd || hz) ? 2'd0 : bus.JumpD ? 2'd3 : bus.JRD ? 2'd2 :
            ((bus.BranchD && eq) || (bus.BranchNeD && !eq)) ? 2'd1 : 2'd0;
      exp = {m_pcf, m_pcf1, tgt_b, bus.RD1D[6:0], bus.JTargetD, sel, hz, hz, sel != 0, hz, m_vd,
             8'(m_tc), m_err};
      act = {bus.PCF, bus.PC_plus1F, bus.PC_BranchD, bus.JR, bus.ins_extend, bus.PCSrcD, bus.StallF,
             bus.StallD, bus.FlushD, bus.FlushE, bus.ValidD, bus.taken_cnt, bus.hazard_err};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
      end
      n_pcf = hz ? m_pcf : sel == 3 ? bus.JTargetD : sel == 2 ? bus.RD1D[6:0] : sel == 1 ? tgt_b : m_pcf1;
      n_vd = hz ? m_vd : sel == 0;
      n_p1d = hz ? m_p1d : sel == 0 ? m_pcf1 : 7'd0;
      n_tc = (sel != 0 && m_tc < 255) ? m_tc + 1 : m_tc;
      n_err = m_err | (hz && m_k >= MAX_WAIT);
      n_k = hz ? m_k + 1 : 0;
      apply = !rst;
      @(posedge clk);
      if (apply) begin
        m_pcf = n_pcf; m_p1d = n_p1d; m_vd = n_vd; m_tc = n_tc; m_err = n_err; m_k = n_k;
      end
    end
  end
  task automatic chk(input string name, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic clr();
    bus.BranchD = 0; bus.BranchNeD = 0; bus.JumpD = 0; bus.JRD = 0;
    bus.RD1D = 0; bus.RD2D = 0; bus.RsD = 0; bus.RtD = 0; bus.ImmD = 0; bus.JTargetD = 0;
    bus.RegWriteE = 0; bus.WriteRegE = 0; bus.MemtoRegM = 0; bus.WriteRegM = 0;
  endtask
  initial begin
    rst = 1;
    clr();
    #1;
    chk("reset_pcf", 16'(bus.PCF), 0);
    chk("reset_valid", 16'(bus.ValidD), 0);
    step(2);
    rst = 0;
    step(127);
    #1 chk("seq_pcf_127", 16'(bus.PCF), 127);
    chk("seq_wrap_plus1", 16'(bus.PC_plus1F), 0);
    step();
    #1 chk("seq_pcf_wrap", 16'(bus.PCF), 0);
    bus.JumpD = 1; bus.JTargetD = 9;
    #1 chk("jmp_src", 16'(bus.PCSrcD), 3);
    step(); clr();
    #1 chk("jmp_pcf", 16'(bus.PCF), 9);
    chk("jmp_bubble", 16'(bus.ValidD), 0);
    chk("jmp_cnt", 16'(bus.taken_cnt), 1);
    step();
    bus.BranchD = 1; bus.RD1D = 5; bus.RD2D = 5; bus.ImmD = 7'h7E;
    #1 chk("br_target", 16'(bus.PC_BranchD), 8);
    chk("br_src", 16'(bus.PCSrcD), 1);
    chk("br_flush", 16'(bus.FlushD), 1);
    step(); clr();
    #1 chk("br_pcf", 16'(bus.PCF), 8);
    chk("br_bubble", 16'(bus.ValidD), 0);
    chk("br_cnt", 16'(bus.taken_cnt), 2);
    step();
    bus.JRD = 1; bus.RsD = 3; bus.RegWriteE = 1; bus.WriteRegE = 3;
    #1 chk("jr_stall", 16'({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD, bus.PCSrcD}), 16'b111000);
    step();
    bus.RegWriteE = 0; bus.RD1D = 16'h0045;
    #1 chk("jr_src", 16'(bus.PCSrcD), 2);
    chk("jr_target", 16'(bus.JR), 16'h45);
    chk("jr_flush", 16'({bus.FlushD, bus.StallF}), 16'b10);
    step(); clr();
    #1 chk("jr_pcf", 16'(bus.PCF), 16'h45);
    step();
    bus.JumpD = 1; bus.BranchD = 1; bus.RD1D = 7; bus.RD2D = 7; bus.JTargetD = 20;
    #1 chk("prio_src", 16'(bus.PCSrcD), 3);
    step(); clr();
    #1 chk("prio_pcf", 16'(bus.PCF), 20);
    step();
    bus.JRD = 1; bus.RegWriteE = 1; bus.WriteRegE = 0; bus.RD1D = 16'h0030;
    #1 chk("r0_nostall", 16'({bus.StallF, bus.PCSrcD}), 16'b010);
    step(); clr();
    step();
    bus.BranchNeD = 1; bus.RD1D = 3; bus.RD2D = 3; bus.ImmD = 3;
    #1 chk("bne_not_taken", 16'({bus.PCSrcD, bus.FlushD}), 0);
    step();
    bus.RD2D = 4;
    #1 chk("bne_taken", 16'(bus.PCSrcD), 1);
    step(); clr();
    step();
    bus.BranchD = 1; bus.RsD = 2; bus.RtD = 4; bus.MemtoRegM = 1; bus.WriteRegM = 4;
    #1 chk("lu_stall", 16'(bus.StallF), 1);
    step();
    #1 chk("lu_err_1", 16'(bus.hazard_err), 0);
    step();
    #1 chk("lu_err_2", 16'(bus.hazard_err), 0);
    step();
    #1 chk("lu_err_3", 16'(bus.hazard_err), 1);
    clr(); step(2);
    #1 chk("lu_err_sticky", 16'(bus.hazard_err), 1);
    bus.JumpD = 1; bus.JTargetD = 5;
    step(520);
    #1 chk("cnt_sat", 16'(bus.taken_cnt), 255);
    clr(); step();
    bus.JRD = 1; bus.RsD = 5; bus.RegWriteE = 1; bus.WriteRegE = 5;
    #1 chk("rst_pre_stall", 16'(bus.StallF), 1);
    step();
    rst = 1;
    #1 chk("rst_async", 16'({bus.PCF, bus.ValidD, bus.taken_cnt, bus.hazard_err, bus.StallF}), 0);
    clr(); step(2);
    rst = 0;
    step(3);
    #1 chk("post_rst_pcf", 16'(bus.PCF), 3);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch/decode-side control-flow controller for the 7-bit-PC pipelined CPU.
- Owns the PC register and the IF/ID PC pipeline register.
- Resolves branch, jump and jump-register in decode, and drives the 2-bit PCSrcD select plus the three candidate targets into the PC source multiplexer.
- Takes the multiplexer's output back as next-PC; stalls on operand hazards and flushes on taken redirects.

Parameters:
- PC_W, 7, PC/target width; all PC arithmetic is modulo 2^PC_W.
- DATA_W, 16, register-file read-data width.
- REG_W, 3, register-specifier width.
- MAX_WAIT, 2, maximum legal consecutive hazard-stall cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_next  in  PC_W  next PC returned from the PC source mux.
- BranchD  in  1  decode: branch-if-equal.
- BranchNeD  in  1  decode: branch-if-not-equal.
- JumpD  in  1  decode: absolute jump.
- JRD  in  1  decode: jump-register.
- RD1D  in  DATA_W  forwarded Rs value.
- RD2D  in  DATA_W  forwarded Rt value.
- RsD  in  REG_W  Rs specifier in decode.
- RtD  in  REG_W  Rt specifier in decode.
- ImmD  in  PC_W  two's-complement branch offset.
- JTargetD  in  PC_W  absolute jump target.
- RegWriteE  in  1  EX stage writes a register.
- WriteRegE  in  REG_W  EX destination register.
- MemtoRegM  in  1  MEM stage is a load.
- WriteRegM  in  REG_W  MEM destination register.
- PCF  out  PC_W  current fetch PC.
- PC_plus1F  out  PC_W  PCF+1.
- PC_BranchD  out  PC_W  branch target.
- JR  out  PC_W  jump-register target.
- ins_extend  out  PC_W  jump target.
- PCSrcD  out  2  next-PC select: 0 = PC+1, 1 = branch, 2 = JR, 3 = jump.
- StallF  out  1  hold PCF.
- StallD  out  1  hold IF/ID.
- FlushD  out  1  squash IF/ID on the next edge.
- FlushE  out  1  insert a bubble into ID/EX.
- ValidD  out  1  decode slot holds a live instruction.
- taken_cnt  out  8  saturating count of taken redirects.
- hazard_err  out  1  sticky: stall exceeded MAX_WAIT.

Behaviour:
- Reset (async): PCF=0, PC_plus1D=0, ValidD=0, state=RUN, wait_cnt=0, taken_cnt=0, hazard_err=0. Combinational outputs follow from these values.
- PC_plus1F = PCF+1, wrapping 127→0. PCF <= PC_next when !StallF.
- IF/ID register, when !StallD:
  - If FlushD: ValidD <= 0, PC_plus1D <= 0.
  - Otherwise: ValidD <= 1, PC_plus1D <= PC_plus1F.
- Targets:
  - PC_BranchD = PC_plus1D + ImmD, modulo 2^PC_W.
  - JR = RD1D[PC_W-1:0].
  - ins_extend = JTargetD.
- EqualD = (RD1D == RD2D).
- Taken conditions (all gated by ValidD):
  - jmp = JumpD.
  - jr = JRD.
  - br = (BranchD & EqualD) | (BranchNeD & !EqualD).
- Priority when multiple are asserted: jump > JR > branch.
- Hazard (gated by ValidD; branch checks Rs and Rt, JR checks Rs only):
  - RegWriteE and WriteRegE != 0 and WriteRegE matches a checked source; or
  - MemtoRegM and WriteRegM != 0 and WriteRegM matches a checked source.
- FSM, state RUN:
  - No hazard: PCSrcD = 3/2/1 for jmp/jr/br, else 0. FlushD = 1 iff PCSrcD != 0. taken_cnt increments (saturating at 255) on each redirect.
  - Hazard: PCSrcD = 0, StallF = StallD = FlushE = 1, no FlushD; go to WAIT with wait_cnt = 1.
- FSM, state WAIT:
  - Same outputs as RUN-with-hazard while the hazard persists; wait_cnt increments, saturating.
  - If wait_cnt reaches MAX_WAIT and the hazard is still present: set hazard_err (sticky until reset) and keep stalling.
  - Hazard clears: behave exactly as RUN in that cycle (redirect allowed); go to RUN, wait_cnt = 0.
- Simultaneous events: the hazard stall always overrides a redirect. Redirect and flush take effect on the same edge: PCF gets the target, the decode slot becomes invalid.
- ValidD=0: no redirect and no hazard, regardless of decode inputs.
- Latency: a taken control transfer costs exactly 1 bubble plus any hazard cycles.
- rst asserted mid-operation: immediate return to the reset values; no pending redirect survives.

Test Plan:
- Sequential fetch, PC_next tied to PC_plus1F: PCF = 0,1,2,…,127,0 (wrap). PCSrcD = 0 and FlushD = 0 throughout.
- BranchD=1, RD1D=RD2D=5, PC_plus1D=10, ImmD=7'h7E (−2), no hazard → PC_BranchD = 8, PCSrcD = 1, FlushD = 1. Next cycle ValidD = 0, taken_cnt = 1.
- JRD=1, RsD=3, RegWriteE=1, WriteRegE=3 → 1 stall cycle (StallF = StallD = FlushE = 1, PCSrcD = 0). Hazard cleared and RD1D=0x0045 → PCSrcD = 2, JR = 7'h45, FlushD = 1.
- JumpD=1 and BranchD=1 with equal operands, JTargetD=20 → PCSrcD = 3, PCF = 20 after the edge.
- Load-use hazard held for 3 cycles → hazard_err = 1 after the cycle in which wait_cnt hits 2; it stays 1 until rst.
- 260 taken jumps → taken_cnt saturates at 255. Assert rst mid-stall → PCF = 0, state RUN, all flags cleared asynchronously.
